// File: rtl/ecc_pkg.sv
// Shared SECDED constants, FSM state type and data-bit position helper for the ECC scrub controller.
package ecc_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned PAR_W   = 6;
  localparam int unsigned CW_W    = 39;
  localparam int unsigned PAR_LSB = 32;
  localparam int unsigned PAR_MSB = 37;
  localparam int unsigned OVR_BIT = 38;
  localparam int unsigned CNT_W   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    CHK  = 2'd2,
    WB   = 2'd3
  } state_t;

  // Hamming position of data bit idx: the idx-th non-power-of-two in 1..38.
  function automatic logic [PAR_W-1:0] data_pos(input int unsigned idx);
    logic [PAR_W-1:0] pos;
    int unsigned      n;
    pos = '0;
    n   = 0;
    for (int unsigned p = 1; p < CW_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (n == idx) pos = PAR_W'(p);
        n++;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/secded_codec.sv
// Combinational SECDED(39,32) encoder and decoder: syndrome, corrected data, single/double error flags.
module secded_codec
  import ecc_pkg::*;
(
  input  logic [DATA_W-1:0] enc_data,
  output logic [CW_W-1:0]   enc_cw_c,
  input  logic [CW_W-1:0]   dec_cw,
  output logic [DATA_W-1:0] dec_data_c,
  output logic              dec_sec_c,
  output logic              dec_ded_c
);

  logic [PAR_W-1:0] enc_par;
  logic [PAR_W-1:0] chk_par;
  logic [PAR_W-1:0] syndrome;
  logic             ovr_err;

  // Parity vector is the XOR of the Hamming positions of all set data bits.
  always_comb begin
    enc_par = '0;
    for (int unsigned j = 0; j < DATA_W; j++) begin
      if (enc_data[j]) enc_par ^= data_pos(j);
    end
    enc_cw_c = {^{enc_par, enc_data}, enc_par, enc_data};
  end

  always_comb begin
    chk_par = '0;
    for (int unsigned j = 0; j < DATA_W; j++) begin
      if (dec_cw[j]) chk_par ^= data_pos(j);
    end
    syndrome   = chk_par ^ dec_cw[PAR_MSB:PAR_LSB];
    ovr_err    = ^dec_cw;
    dec_sec_c  = ovr_err;
    dec_ded_c  = !ovr_err && (syndrome != '0);
    dec_data_c = dec_cw[DATA_W-1:0];
    // Only a data-bit syndrome flips data; parity or overall-bit hits leave it intact.
    if (ovr_err) begin
      for (int unsigned j = 0; j < DATA_W; j++) begin
        if (syndrome == data_pos(j)) dec_data_c[j] = ~dec_cw[j];
      end
    end
  end

endmodule

// File: rtl/ecc_scrub_ctrl.sv
// SECDED-protected SRAM controller with host port and background scrubber.
// Define ECC_AUTO_WB_EN to write corrected codewords back after a single-bit error.
module ecc_scrub_ctrl
  import ecc_pkg::*;
#(
  parameter int unsigned ADDR_W         = 10,
  parameter int unsigned SCRUB_INTERVAL = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_sec,
  output logic              rsp_ded,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [CW_W-1:0]   mem_wdata,
  input  logic [CW_W-1:0]   mem_rdata,
  input  logic              scrub_en,
  output logic [CNT_W-1:0]  sec_cnt,
  output logic [CNT_W-1:0]  ded_cnt,
  output logic [ADDR_W-1:0] ded_addr
);

  localparam int unsigned TIMER_W = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;

  state_t              state;
  logic                is_scrub;
  logic                scrub_pending;
  logic [ADDR_W-1:0]   scrub_addr;
  logic [TIMER_W-1:0]  timer;
  logic [DATA_W-1:0]   enc_data;
  logic [CW_W-1:0]     enc_cw_c;
  logic [DATA_W-1:0]   dec_data_c;
  logic                dec_sec_c;
  logic                dec_ded_c;

  // One encoder serves host writes (IDLE) and writeback of corrected data (CHK).
  assign enc_data = (state == CHK) ? dec_data_c : req_wdata;

  secded_codec u_codec (
    .enc_data   (enc_data),
    .enc_cw_c   (enc_cw_c),
    .dec_cw     (mem_rdata),
    .dec_data_c (dec_data_c),
    .dec_sec_c  (dec_sec_c),
    .dec_ded_c  (dec_ded_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      is_scrub      <= 1'b0;
      scrub_pending <= 1'b0;
      scrub_addr    <= '0;
      timer         <= '0;
      req_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_sec       <= 1'b0;
      rsp_ded       <= 1'b0;
      mem_en        <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      sec_cnt       <= '0;
      ded_cnt       <= '0;
      ded_addr      <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          mem_en    <= 1'b0;
          mem_we    <= 1'b0;
          req_ready <= 1'b1;
          // Host traffic always wins over a pending scrub.
          if (req_ready && req_valid) begin
            mem_en   <= 1'b1;
            mem_we   <= req_we;
            mem_addr <= req_addr;
            if (req_we) begin
              mem_wdata <= enc_cw_c;
            end else begin
              state     <= RD;
              is_scrub  <= 1'b0;
              req_ready <= 1'b0;
            end
          end else if (req_ready && scrub_pending) begin
            mem_en        <= 1'b1;
            mem_addr      <= scrub_addr;
            state         <= RD;
            is_scrub      <= 1'b1;
            req_ready     <= 1'b0;
            scrub_pending <= 1'b0;
          end
        end
        RD: begin
          mem_en <= 1'b0;
          state  <= CHK;
        end
        CHK: begin
          if (!is_scrub) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= dec_data_c;
            rsp_sec   <= dec_sec_c;
            rsp_ded   <= dec_ded_c;
          end else begin
            scrub_addr <= scrub_addr + ADDR_W'(1);
          end
          if (dec_sec_c && (sec_cnt != '1)) sec_cnt <= sec_cnt + CNT_W'(1);
          if (dec_ded_c && (ded_cnt != '1)) ded_cnt <= ded_cnt + CNT_W'(1);
          if (dec_ded_c) ded_addr <= mem_addr;
`ifdef ECC_AUTO_WB_EN
          if (dec_sec_c) begin
            state     <= WB;
            mem_en    <= 1'b1;
            mem_we    <= 1'b1;
            mem_wdata <= enc_cw_c;
          end else begin
            state     <= IDLE;
            req_ready <= 1'b1;
          end
`else
          state     <= IDLE;
          req_ready <= 1'b1;
`endif
        end
        WB: begin
          mem_en    <= 1'b0;
          mem_we    <= 1'b0;
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
      // Interval timer; a new expiry overrides the clear from a scrub start.
      if (!scrub_en) begin
        timer         <= '0;
        scrub_pending <= 1'b0;
      end else if (timer == TIMER_W'(SCRUB_INTERVAL - 1)) begin
        timer         <= '0;
        scrub_pending <= 1'b1;
      end else begin
        timer <= timer + TIMER_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// Directed self-checking bench for ecc_scrub_ctrl with a behavioural SRAM and error injection.
module tb_ecc_scrub_ctrl;

`ifdef ECC_AUTO_WB_EN
  localparam bit WB_ON = 1'b1;
`else
  localparam bit WB_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [9:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_sec;
  logic        rsp_ded;
  logic        mem_en;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [38:0] mem_wdata;
  logic [38:0] mem_rdata = '0;
  logic        scrub_en = 1'b0;
  logic [15:0] sec_cnt;
  logic [15:0] ded_cnt;
  logic [9:0]  ded_addr;

  logic [38:0] mem [0:1023];
  logic        mem_clr = 1'b0;
  logic        inj_en = 1'b0;
  logic [9:0]  inj_addr = '0;
  logic [38:0] inj_mask = '0;
  int          wr_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  ecc_scrub_ctrl #(.ADDR_W(10), .SCRUB_INTERVAL(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_sec(rsp_sec), .rsp_ded(rsp_ded),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .scrub_en(scrub_en), .sec_cnt(sec_cnt), .ded_cnt(ded_cnt), .ded_addr(ded_addr)
  );

  always #5 clk = ~clk;

  // SRAM model: one-cycle read latency, plus clear and bit-flip injection hooks.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
    end else begin
      if (mem_en && mem_we) begin
        mem[mem_addr] <= mem_wdata;
        wr_cnt <= wr_cnt + 1;
      end
      if (inj_en) mem[inj_addr] <= mem[inj_addr] ^ inj_mask;
      if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Reference encoder: lay out the 38-position Hamming word explicitly.
  function automatic logic [38:0] tb_encode(input logic [31:0] d);
    logic [38:1] h;
    logic [5:0]  p;
    int          k;
    h = '0;
    k = 0;
    for (int pos = 1; pos <= 38; pos++) begin
      if (pos != 1 && pos != 2 && pos != 4 && pos != 8 && pos != 16 && pos != 32) begin
        h[pos] = d[k];
        k++;
      end
    end
    for (int b = 0; b < 6; b++) begin
      p[b] = 1'b0;
      for (int pos = 1; pos <= 38; pos++) begin
        if (((pos >> b) & 1) == 1) p[b] = p[b] ^ h[pos];
      end
    end
    return {^{p, d}, p, d};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic inject(input logic [9:0] a, input logic [38:0] mask);
    @(negedge clk);
    inj_en = 1'b1; inj_addr = a; inj_mask = mask;
    @(negedge clk);
    inj_en = 1'b0;
  endtask

  task automatic host_write(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    check("wr_ready", 64'(req_ready), 64'(1));
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0;
    check("wr_strobe", 64'({mem_en, mem_we}), 64'(2'b11));
    check("wr_addr", 64'(mem_addr), 64'(a));
    check("wr_cw", 64'(mem_wdata), 64'(tb_encode(d)));
  endtask

  task automatic host_read(input logic [9:0] a, output logic [31:0] rd,
                           output logic sec, output logic ded);
    @(negedge clk);
    check("rd_ready", 64'(req_ready), 64'(1));
    req_valid = 1'b1; req_we = 1'b0; req_addr = a;
    @(negedge clk);
    req_valid = 1'b0;
    check("rd_strobe", 64'({mem_en, mem_we, mem_addr}), 64'({2'b10, a}));
    @(negedge clk);
    check("rd_early", 64'(rsp_valid), 64'(0));
    @(negedge clk);
    check("rd_latency", 64'(rsp_valid), 64'(1));
    rd = rsp_rdata; sec = rsp_sec; ded = rsp_ded;
    @(negedge clk);
    check("rd_pulse", 64'(rsp_valid), 64'(0));
  endtask

  initial begin
    logic [31:0] rd;
    logic        sec, ded;
    int          w0, exp_sec, exp_ded;
    int          seen, bad, rsp_seen, cyc, exp_a;
    logic [9:0]  a3ff, awrap;
    bit          found;

    // Reset and idle outputs
    mem_clr = 1'b1;
    repeat (3) @(negedge clk);
    mem_clr = 1'b0;
    check("rst_ctl", 64'({req_ready, rsp_valid, rsp_sec, rsp_ded, mem_en, mem_we}), 64'(0));
    check("rst_cnt", 64'({sec_cnt, ded_cnt, ded_addr, mem_addr}), 64'(0));
    check("rst_data", 64'({rsp_rdata, mem_wdata[31:0]}), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'(1));
    exp_sec = 0; exp_ded = 0;

    // Clean write/read round trip
    host_write(10'h005, 32'hDEADBEEF);
    host_read(10'h005, rd, sec, ded);
    check("a_rdata", 64'(rd), 64'h0000_0000_DEAD_BEEF);
    check("a_flags", 64'({sec, ded}), 64'(0));

    // Single data-bit error, corrected, optionally written back
    inject(10'h005, 39'(1) << 7);
    w0 = wr_cnt;
    host_read(10'h005, rd, sec, ded);
    exp_sec++;
    check("b_rdata", 64'(rd), 64'h0000_0000_DEAD_BEEF);
    check("b_flags", 64'({sec, ded}), 64'(2'b10));
    check("b_sec_cnt", 64'(sec_cnt), 64'(exp_sec));
    check("b_wb_count", 64'(wr_cnt - w0), WB_ON ? 64'(1) : 64'(0));
    check("b_wb_cw", 64'(mem[5]), WB_ON ? 64'(tb_encode(32'hDEADBEEF))
                                        : 64'(tb_encode(32'hDEADBEEF) ^ (39'(1) << 7)));
    host_read(10'h005, rd, sec, ded);
    if (!WB_ON) exp_sec++;
    check("b_reread_sec", 64'(sec), WB_ON ? 64'(0) : 64'(1));
    check("b_reread_cnt", 64'(sec_cnt), 64'(exp_sec));

    // Double error: flagged, address captured, never written back
    host_write(10'h010, 32'h12345678);
    inject(10'h010, (39'(1) << 3) | (39'(1) << 20));
    w0 = wr_cnt;
    host_read(10'h010, rd, sec, ded);
    exp_ded++;
    check("c_flags", 64'({sec, ded}), 64'(2'b01));
    check("c_ded_cnt", 64'(ded_cnt), 64'(exp_ded));
    check("c_ded_addr", 64'(ded_addr), 64'h010);
    check("c_no_we", 64'(wr_cnt - w0), 64'(0));
    check("c_sec_cnt", 64'(sec_cnt), 64'(exp_sec));

    // Parity-bit and overall-bit errors leave data intact
    host_write(10'h020, 32'hA5A5A5A5);
    inject(10'h020, 39'(1) << 34);
    host_read(10'h020, rd, sec, ded);
    exp_sec++;
    check("d_par_rdata", 64'(rd), 64'h0000_0000_A5A5_A5A5);
    check("d_par_flags", 64'({sec, ded}), 64'(2'b10));
    host_write(10'h021, 32'hFFFFFFFF);
    inject(10'h021, 39'(1) << 38);
    host_read(10'h021, rd, sec, ded);
    exp_sec++;
    check("d_ovr_rdata", 64'(rd), 64'h0000_0000_FFFF_FFFF);
    check("d_ovr_flags", 64'({sec, ded}), 64'(2'b10));
    host_write(10'h022, 32'h00000000);
    host_read(10'h022, rd, sec, ded);
    check("d_zero", 64'({rd, sec, ded}), 64'(0));
    check("d_sec_cnt", 64'(sec_cnt), 64'(exp_sec));

    // Restore clean contents, then plant an error for the scrubber
    host_write(10'h005, 32'hDEADBEEF);
    host_write(10'h010, 32'h0);
    host_write(10'h020, 32'h0);
    host_write(10'h021, 32'h0);
    inject(10'h3FF, 39'(1));

    // Host read arrives in the cycle scrub_pending first rises
    @(negedge clk);
    scrub_en = 1'b1;
    repeat (4) @(negedge clk);
    check("e_ready", 64'(req_ready), 64'(1));
    req_valid = 1'b1; req_we = 1'b0; req_addr = 10'h005;
    @(negedge clk);
    req_valid = 1'b0;
    check("e_host_first", 64'({mem_en, mem_we, mem_addr}), 64'({2'b10, 10'h005}));
    repeat (2) @(negedge clk);
    check("e_host_rsp", 64'({rsp_valid, rsp_rdata}), 64'({1'b1, 32'hDEADBEEF}));
    found = 1'b0; rsp_seen = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clk);
      if (rsp_valid) rsp_seen++;
      if (mem_en && !mem_we) begin
        found = 1'b1;
        check("e_scrub_addr", 64'(mem_addr), 64'(0));
      end
    end
    check("e_scrub_seen", 64'(found), 64'(1));

    // Full sweep: addresses 1..1023 then wrap to 0
    seen = 0; bad = 0; cyc = 0; exp_a = 1; a3ff = '0; awrap = 10'h155;
    while (seen < 1024 && cyc < 10000) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid) rsp_seen++;
      if (mem_en && !mem_we) begin
        if (mem_addr !== 10'(exp_a)) bad++;
        if (seen == 1022) a3ff = mem_addr;
        if (seen == 1023) awrap = mem_addr;
        seen++;
        exp_a = (exp_a + 1) % 1024;
      end
    end
    scrub_en = 1'b0;
    repeat (6) @(negedge clk);
    exp_sec++;
    check("f_scrub_count", 64'(seen), 64'(1024));
    check("f_addr_seq", 64'(bad), 64'(0));
    check("f_addr_3ff", 64'(a3ff), 64'h3FF);
    check("f_addr_wrap", 64'(awrap), 64'h000);
    check("f_silent", 64'(rsp_seen), 64'(0));
    check("f_sec_cnt", 64'(sec_cnt), 64'(exp_sec));
    check("f_ded_cnt", 64'(ded_cnt), 64'(exp_ded));
    check("f_scrub_wb", 64'(mem[10'h3FF]), WB_ON ? 64'(0) : 64'(1));

    // Reset while a corrected read is in CHK/WB aborts it
    host_write(10'h030, 32'h0BADF00D);
    inject(10'h030, 39'(1) << 12);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 10'h030;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    if (!WB_ON) rst_n = 1'b0;
    @(negedge clk);
    if (WB_ON) begin
      check("g_in_wb", 64'({mem_en, mem_we}), 64'(2'b11));
      rst_n = 1'b0;
    end else begin
      check("g_no_rsp", 64'(rsp_valid), 64'(0));
    end
    @(negedge clk);
    check("g_rst_ctl", 64'({req_ready, rsp_valid, mem_en, mem_we}), 64'(0));
    check("g_rst_cnt", 64'({sec_cnt, ded_cnt, ded_addr}), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("g_ready", 64'({req_ready, mem_we}), 64'(2'b10));
    host_read(10'h005, rd, sec, ded);
    check("g_post_rd", 64'({rd, sec, ded}), 64'({32'hDEADBEEF, 2'b00}));
    check("g_post_cnt", 64'(sec_cnt), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
